// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : state encodings, defaults and parity shared by TX and RX   |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int unsigned c_DEF_TICKS_PER_BIT = 16;
    localparam int unsigned c_DEF_DATA_BITS     = 8;
    localparam int unsigned c_MAX_DATA_BITS     = 8;

    // Narrow frames are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic uart_parity(input logic [c_MAX_DATA_BITS-1:0] i_data,
                                         input logic                       i_odd);
        return (^i_data) ^ i_odd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_if : byte handshake between the TX FIFO side and uart_tx      |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
interface uart_tx_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = c_DEF_DATA_BITS
) ();

    logic                 i_start;
    logic [DATA_BITS-1:0] i_din;
    logic                 o_tx_busy;
    logic                 o_tx_done;

    modport master (
        output i_start,
        output i_din,
        input  o_tx_busy,
        input  o_tx_done
    );

    modport slave (
        input  i_start,
        input  i_din,
        output o_tx_busy,
        output o_tx_done
    );

endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx : start/data/parity/stop serialiser on oversampled baud tick  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned TICKS_PER_BIT = c_DEF_TICKS_PER_BIT,
    parameter int unsigned DATA_BITS     = c_DEF_DATA_BITS,
    parameter bit          PARITY_EN     = 1'b0,
    parameter bit          PARITY_ODD    = 1'b0,
    parameter int unsigned STOP_BITS     = 1
) (
    input  wire logic  clk,
    input  wire logic  rst,
    input  wire logic  baud_tick,
    uart_tx_if.slave   bus,
    output logic       o_tx
);

    localparam int unsigned              c_TICK_W    = $clog2(TICKS_PER_BIT);
    localparam logic [c_TICK_W-1:0]      c_TICK_LAST = c_TICK_W'(TICKS_PER_BIT - 1);
    localparam logic [2:0]               c_BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic [2:0]               c_STOP_LAST = 3'(STOP_BITS - 1);

    uart_state_t                 r_state;
    logic [c_TICK_W-1:0]         r_tick;
    logic [2:0]                  r_bit;
    logic [DATA_BITS-1:0]        r_shift;
    logic                        r_parity;
    logic                        r_busy;
    logic                        r_done;

    logic                        w_bit_end;
    logic [DATA_BITS-1:0]        w_shift_next;
    logic [c_MAX_DATA_BITS-1:0]  w_din_ext;

    assign w_bit_end    = baud_tick && (r_tick == c_TICK_LAST);
    assign w_shift_next = r_shift >> 1;
    assign w_din_ext    = c_MAX_DATA_BITS'(bus.i_din);

    assign bus.o_tx_busy = r_busy;
    assign bus.o_tx_done = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_tick   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            o_tx     <= 1'b1;
        end else begin
            r_done <= 1'b0;

            // The tick counter only runs inside a frame; the acceptance cycle never counts.
            if (r_state != ST_IDLE && baud_tick) begin
                r_tick <= w_bit_end ? '0 : r_tick + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    o_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (bus.i_start) begin
                        r_shift  <= bus.i_din;
                        r_parity <= uart_parity(w_din_ext, PARITY_ODD);
                        r_tick   <= '0;
                        r_state  <= ST_START;
                        o_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end

                ST_START: begin
                    if (w_bit_end) begin
                        r_state <= ST_DATA;
                        r_bit   <= '0;
                        o_tx    <= r_shift[0];
                    end
                end

                ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit == c_BIT_LAST) begin
                            r_bit <= '0;
                            if (PARITY_EN) begin
                                r_state <= ST_PARITY;
                                o_tx    <= r_parity;
                            end else begin
                                r_state <= ST_STOP;
                                o_tx    <= 1'b1;
                            end
                        end else begin
                            r_shift <= w_shift_next;
                            r_bit   <= r_bit + 1'b1;
                            o_tx    <= w_shift_next[0];
                        end
                    end
                end

                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= ST_STOP;
                        r_bit   <= '0;
                        o_tx    <= 1'b1;
                    end
                end

                ST_STOP: begin
                    o_tx <= 1'b1;
                    if (w_bit_end) begin
                        if (r_bit == c_STOP_LAST) begin
                            r_state <= ST_IDLE;
                            r_bit   <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    o_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_uart_tx : four parameterisations driven by directed frame vectors  |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] r_div = 2'd0;
    wire        baud_tick = (r_div == 2'd3);
    int         cyc = 0;

    logic       start_v [4];
    logic [7:0] din_v   [4];
    wire  [3:0] tx_w;
    wire  [3:0] busy_w;
    wire  [3:0] done_w;
    int         done_cnt [4];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        r_div <= r_div + 2'd1;
        cyc   <= cyc + 1;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (done_w[i]) done_cnt[i] <= done_cnt[i] + 1;
        end
    end

    uart_tx_if #(.DATA_BITS(8)) if0 ();
    uart_tx_if #(.DATA_BITS(8)) if1 ();
    uart_tx_if #(.DATA_BITS(8)) if2 ();
    uart_tx_if #(.DATA_BITS(8)) if3 ();

    assign if0.i_start = start_v[0];  assign if0.i_din = din_v[0];
    assign if1.i_start = start_v[1];  assign if1.i_din = din_v[1];
    assign if2.i_start = start_v[2];  assign if2.i_din = din_v[2];
    assign if3.i_start = start_v[3];  assign if3.i_din = din_v[3];
    assign busy_w = {if3.o_tx_busy, if2.o_tx_busy, if1.o_tx_busy, if0.o_tx_busy};
    assign done_w = {if3.o_tx_done, if2.o_tx_done, if1.o_tx_done, if0.o_tx_done};

    uart_tx u_dut0 (.clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(if0), .o_tx(tx_w[0]));

    uart_tx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut_pe (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(if1), .o_tx(tx_w[1]));

    uart_tx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_dut_po (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(if2), .o_tx(tx_w[2]));

    uart_tx #(.STOP_BITS(2)) u_dut_s2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(if3), .o_tx(tx_w[3]));

    typedef struct {
        int         sel;
        logic [7:0] data;
        string      exp;
    } vec_t;

    vec_t vecs [7];

    task automatic set_vec(input int idx, input int sel, input logic [7:0] data, input string exp);
        vecs[idx].sel  = sel;
        vecs[idx].data = data;
        vecs[idx].exp  = exp;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
        end
    endtask

    task automatic send(input int sel, input logic [7:0] d);
        din_v[sel]   = d;
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
    endtask

    // Line receiver: find the start bit, then sample near mid-bit every 64 clk.
    task automatic rx_frame(input int sel, input int nbits, output string s, output logic busy_ok);
        logic found;
        s       = "";
        busy_ok = 1'b1;
        found   = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (tx_w[sel] == 1'b0) found = 1'b1;
        end
        if (!found) return;
        repeat (31) @(negedge clk);
        for (int k = 0; k < nbits; k++) begin
            if (k > 0) repeat (64) @(negedge clk);
            if (tx_w[sel]) s = {s, "1"};
            else           s = {s, "0"};
            if (!busy_w[sel]) busy_ok = 1'b0;
        end
    endtask

    task automatic wait_done(input int sel, output logic found);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (done_w[sel]) found = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string      s;
        logic       bok;
        logic       f;
        int         d0;
        int         ca, cr, cd;
        int         tt [$];
        logic       prev;
        int         bad;

        for (int i = 0; i < 4; i++) begin
            start_v[i] = 1'b0;
            din_v[i]   = 8'h00;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx",   int'(tx_w),   4'hF);
        check("reset_busy", int'(busy_w), 0);
        check("reset_done", int'(done_w), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        set_vec(0, 0, 8'h55, "0101010101");
        set_vec(1, 1, 8'hA3, "01100010101");
        set_vec(2, 2, 8'hA3, "01100010111");
        set_vec(3, 3, 8'h81, "01000000111");
        set_vec(4, 0, 8'h00, "0000000001");
        set_vec(5, 0, 8'hFF, "0111111111");
        set_vec(6, 0, 8'h3C, "0001111001");

        for (int v = 0; v < 7; v++) begin
            d0 = done_cnt[vecs[v].sel];
            send(vecs[v].sel, vecs[v].data);
            rx_frame(vecs[v].sel, vecs[v].exp.len(), s, bok);
            check_str($sformatf("vec%0d_bits", v), s, vecs[v].exp);
            check($sformatf("vec%0d_busy_in_frame", v), int'(bok), 1);
            wait_done(vecs[v].sel, f);
            check($sformatf("vec%0d_done_seen", v), int'(f), 1);
            @(negedge clk);
            check($sformatf("vec%0d_done_one_clk", v), int'(done_w[vecs[v].sel]), 0);
            check($sformatf("vec%0d_idle_busy", v), int'(busy_w[vecs[v].sel]), 0);
            check($sformatf("vec%0d_done_count", v), done_cnt[vecs[v].sel] - d0, 1);
            repeat (5) @(negedge clk);
        end

        // 0x55 alternates every bit, so every data-bit edge spacing is visible.
        d0 = done_cnt[0];
        send(0, 8'h55);
        tt.delete();
        prev = tx_w[0];
        f = 1'b0;
        for (int i = 0; i < 1000 && !f; i++) begin
            @(negedge clk);
            if (tx_w[0] !== prev) begin
                tt.push_back(cyc);
                prev = tx_w[0];
            end
            if (done_w[0]) f = 1'b1;
        end
        check("t55_done_seen", int'(f), 1);
        check("t55_edges", tt.size(), 9);
        bad = 0;
        for (int k = 1; k < tt.size(); k++) if (tt[k] - tt[k-1] != 64) bad++;
        check("t55_bit_len_64clk", bad, 0);
        repeat (2) @(negedge clk);
        check("t55_done_count", done_cnt[0] - d0, 1);

        // Back-to-back: restart in the done cycle.
        send(0, 8'h00);
        rx_frame(0, 10, s, bok);
        check_str("b2b_first_bits", s, "0000000001");
        wait_done(0, f);
        check("b2b_first_done", int'(f), 1);
        check("b2b_tx_high_in_done", int'(tx_w[0]), 1);
        start_v[0] = 1'b1;
        din_v[0]   = 8'hFF;
        @(negedge clk);
        start_v[0] = 1'b0;
        check("b2b_start_next_clk", int'(tx_w[0]), 0);
        check("b2b_busy_next_clk", int'(busy_w[0]), 1);
        rx_frame(0, 10, s, bok);
        check_str("b2b_second_bits", s, "0111111111");
        wait_done(0, f);
        check("b2b_second_done", int'(f), 1);
        repeat (5) @(negedge clk);

        // i_start and i_din change while busy must not disturb the frame.
        d0 = done_cnt[0];
        send(0, 8'h34);
        fork
            rx_frame(0, 10, s, bok);
            begin
                repeat (200) @(negedge clk);
                din_v[0]   = 8'h12;
                start_v[0] = 1'b1;
                @(negedge clk);
                start_v[0] = 1'b0;
            end
        join
        check_str("busy_ignore_bits", s, "0001011001");
        wait_done(0, f);
        check("busy_ignore_done", int'(f), 1);
        repeat (150) @(negedge clk);
        check("busy_ignore_no_requeue_tx", int'(tx_w[0]), 1);
        check("busy_ignore_no_requeue_busy", int'(busy_w[0]), 0);
        check("busy_ignore_done_count", done_cnt[0] - d0, 1);

        // Reset during data bit 3 (a 0 bit of 0x81).
        send(0, 8'h81);
        f = 1'b0;
        for (int i = 0; i < 400 && !f; i++) begin
            @(negedge clk);
            if (tx_w[0] == 1'b0) f = 1'b1;
        end
        repeat (31 + 256) @(negedge clk);
        check("rst_mid_pre_tx_low", int'(tx_w[0]), 0);
        d0 = done_cnt[0];
        rst = 1'b1;
        #1;
        check("rst_mid_tx_async", int'(tx_w[0]), 1);
        check("rst_mid_busy_async", int'(busy_w[0]), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check("rst_mid_tx_idle", int'(tx_w[0]), 1);
        check("rst_mid_no_done", done_cnt[0] - d0, 0);
        send(0, 8'h81);
        rx_frame(0, 10, s, bok);
        check_str("rst_after_bits", s, "0100000011");
        wait_done(0, f);
        check("rst_after_done", int'(f), 1);
        repeat (5) @(negedge clk);

        // Two stop bits: 128 clk of stop, 704 clk frame minus start-bit phase.
        send(3, 8'h00);
        ca = cyc;
        check("s2_start_low", int'(tx_w[3]), 0);
        f = 1'b0;
        for (int i = 0; i < 1000 && !f; i++) begin
            @(negedge clk);
            if (tx_w[3] == 1'b1) f = 1'b1;
        end
        cr = cyc;
        wait_done(3, f);
        cd = cyc;
        check("s2_done_seen", int'(f), 1);
        check("s2_stop_len_128clk", cd - cr, 128);
        checks++;
        if (!(cd - ca > 700 && cd - ca <= 704)) begin
            failures++;
            $display("FAIL s2_frame_len: got %0d clk required 701..704", cd - ca);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
